// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// The master modport is the controller. It reads hazard information from the
// ID/EX/MEM stages and drives the stage enables, hold, bubble and flush strobes.
// The slave modport is the datapath side.
// There is no valid/ready handshake on this bundle. Every signal is a level that
// is sampled on each rising clock edge. The controller outputs depend only on the
// current inputs and the registered state, and they are valid in the same cycle.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    // hazard information from the datapath
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_re;
    logic                  mem_access;
    logic                  dmem_ready;
    logic                  branch_taken;

    // strobes back to the datapath
    logic                  pc_load;
    logic                  if_id_load;
    logic                  pipe_hold;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic [1:0]            ctrl_state;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_re,
               mem_access, dmem_ready, branch_taken,
        output pc_load, if_id_load, pipe_hold, id_ex_bubble,
               if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_re,
               mem_access, dmem_ready, branch_taken,
        input  pc_load, if_id_load, pipe_hold, id_ex_bubble,
               if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Per-cycle priority is: data-memory wait, then taken branch, then load-use, then normal flow.
// The strobes are combinational from state and inputs. The state and the flush counter
// are registered.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the saturating stall_cnt/flush_cnt outputs.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t          state, next_state;
    logic [2:0]      cnt, next_cnt;

    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic            load_use;
    logic            mem_stall;

    logic            pc_load_c, if_id_load_c, pipe_hold_c, bubble_c;
    logic            if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;

    assign rs1 = hz.id_rs1;
    assign rs2 = hz.id_rs2;
    assign rd  = hz.ex_rd;

    // A load in EX whose destination is read by the instruction in ID; x0 never hazards
    assign load_use = hz.ex_mem_re && (rd != '0) &&
                      ((hz.id_uses_rs1 && (rs1 == rd)) ||
                       (hz.id_uses_rs2 && (rs2 == rd)));

    assign mem_stall = hz.mem_access && !hz.dmem_ready;

    // State and flush-counter register; reset drops any pending wait or redirect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and strobe decode; MEM_WAIT decodes exactly like RUN, because a
    // release cycle is a normal RUN cycle with the memory condition gone
    always_comb begin
        pc_load_c      = 1'b0;
        if_id_load_c   = 1'b0;
        pipe_hold_c    = 1'b0;
        bubble_c       = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        next_state     = state;
        next_cnt       = cnt;

        case (state)
            REDIRECT: begin
                if (mem_stall) begin
                    pipe_hold_c = 1'b1;
                    next_state  = MEM_WAIT;
                    next_cnt    = '0;
                end else if (hz.branch_taken) begin
                    // cannot normally happen since EX/MEM was flushed; restart the redirect
                    pc_load_c      = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    next_state     = REDIRECT;
                    next_cnt       = FLUSH_INIT;
                end else begin
                    // ID still holds a squashed NOP, so a load-use match here is ignored
                    pc_load_c     = 1'b1;
                    if_id_load_c  = 1'b1;
                    if_id_flush_c = 1'b1;
                    next_cnt      = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end
                end
            end
            default: begin
                if (mem_stall) begin
                    pipe_hold_c = 1'b1;
                    next_state  = MEM_WAIT;
                end else if (hz.branch_taken) begin
                    // a coincident load-use belongs to a wrong-path instruction and is dropped
                    pc_load_c      = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_flush_c  = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    next_state     = REDIRECT;
                    next_cnt       = FLUSH_INIT;
                end else if (load_use) begin
                    // one bubble is enough: next cycle the load is in MEM and ex_mem_re drops
                    bubble_c   = 1'b1;
                    next_state = RUN;
                end else begin
                    pc_load_c    = 1'b1;
                    if_id_load_c = 1'b1;
                    next_state   = RUN;
                end
            end
        endcase
    end

    // Output drive; while reset is high the whole pipe is frozen and cleared
    always_comb begin
        hz.pc_load      = reset ? 1'b0 : pc_load_c;
        hz.if_id_load   = reset ? 1'b0 : if_id_load_c;
        hz.pipe_hold    = reset ? 1'b1 : pipe_hold_c;
        hz.id_ex_bubble = reset ? 1'b0 : bubble_c;
        hz.if_id_flush  = reset ? 1'b1 : if_id_flush_c;
        hz.id_ex_flush  = reset ? 1'b1 : id_ex_flush_c;
        hz.ex_mem_flush = reset ? 1'b1 : ex_mem_flush_c;
        hz.ctrl_state   = reset ? 2'd0 : state;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counters: cycles without a PC advance, and redirect entries
    // (ex_mem_flush outside reset is raised only by an accepted branch)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_load_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_mem_flush_c && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule
